// File: rtl/sema_byte_reader.sv
// Serial-to-byte reader for the semaphore channel: LSB-first bit assembly with a one-deep holding register.
// Optional even-parity frame bit enabled by defining SEMA_RX_PARITY_EN.
module sema_byte_reader (
  input  logic       clk_s,
  input  logic       rst_s,
  input  logic       sema_data_i_s,
  input  logic       sema_valid_i_s,
  output logic       sema_ready_o_s,
  output logic [7:0] byte_data_o_s,
  output logic       byte_valid_o_s,
  input  logic       byte_ready_i_s,
  output logic       byte_perr_o_s,
  output logic [7:0] frame_cnt_o_s
);

  // state | meaning
  // IDLE  | bit count 0, waiting for first bit of a frame
  // SHIFT | bit counts 1-7, assembling data bits
  // PAR   | bit count 8, waiting for the parity bit (parity build only)
  // STALL | frame complete, holding register still occupied
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
`ifdef SEMA_RX_PARITY_EN
    , PAR = 2'd3
`endif
  } state_t;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       xfer;
  logic       drain;
  logic       hold_free;
  logic       frame_done;
  logic [7:0] asm_byte;

  assign xfer      = sema_valid_i_s & sema_ready_o_s;
  assign drain     = byte_valid_o_s & byte_ready_i_s;
  assign hold_free = ~byte_valid_o_s | byte_ready_i_s;

`ifdef SEMA_RX_PARITY_EN
  logic par_q;
  logic pend_perr_q;
  logic perr_q;
  logic asm_perr;

  assign byte_perr_o_s = perr_q;

  always_comb begin
    asm_byte   = shift_q;
    asm_perr   = par_q ^ sema_data_i_s;
    frame_done = xfer && (state_q == PAR);
  end
`else
  assign byte_perr_o_s = 1'b0;

  always_comb begin
    asm_byte   = {sema_data_i_s, shift_q[7:1]};
    frame_done = xfer && (state_q == SHIFT) && (bit_cnt_q == 4'd7);
  end
`endif

  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 4'd0;
      shift_q        <= 8'h00;
      byte_data_o_s  <= 8'h00;
      byte_valid_o_s <= 1'b0;
      frame_cnt_o_s  <= 8'h00;
      sema_ready_o_s <= 1'b0;
`ifdef SEMA_RX_PARITY_EN
      par_q          <= 1'b0;
      pend_perr_q    <= 1'b0;
      perr_q         <= 1'b0;
`endif
    end else begin
      sema_ready_o_s <= 1'b1;

      if (drain) begin
        frame_cnt_o_s  <= frame_cnt_o_s + 8'd1;
        byte_valid_o_s <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (xfer) begin
            shift_q   <= {sema_data_i_s, shift_q[7:1]};
            bit_cnt_q <= 4'd1;
            state_q   <= SHIFT;
`ifdef SEMA_RX_PARITY_EN
            par_q     <= sema_data_i_s;
`endif
          end
        end
        SHIFT: begin
          if (xfer) begin
            shift_q   <= {sema_data_i_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
`ifdef SEMA_RX_PARITY_EN
            par_q     <= par_q ^ sema_data_i_s;
            if (bit_cnt_q == 4'd7) state_q <= PAR;
`endif
          end
        end
`ifdef SEMA_RX_PARITY_EN
        PAR: begin
          // completion is handled below with the other frame-done paths
        end
`endif
        STALL: begin
          if (byte_ready_i_s) begin
            byte_data_o_s  <= shift_q;
            byte_valid_o_s <= 1'b1;
            state_q        <= IDLE;
            bit_cnt_q      <= 4'd0;
`ifdef SEMA_RX_PARITY_EN
            perr_q         <= pend_perr_q;
`endif
          end else begin
            sema_ready_o_s <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Later assignments override the per-state updates on the completing edge.
      if (frame_done) begin
        bit_cnt_q <= 4'd0;
        if (hold_free) begin
          byte_data_o_s  <= asm_byte;
          byte_valid_o_s <= 1'b1;
          state_q        <= IDLE;
`ifdef SEMA_RX_PARITY_EN
          perr_q         <= asm_perr;
`endif
        end else begin
          shift_q        <= asm_byte;
          state_q        <= STALL;
          sema_ready_o_s <= 1'b0;
`ifdef SEMA_RX_PARITY_EN
          pend_perr_q    <= asm_perr;
`endif
        end
      end
    end
  end

endmodule

// File: doc/sema_byte_reader.md
SEMA_BYTE_READER -- requirements
Module: sema_byte_reader

Interface
REQ-001 The block SHALL have port clk_s, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have port rst_s, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port sema_data_i_s, input, 1 bit: serial bit from the semaphore channel.
REQ-004 The block SHALL have port sema_valid_i_s, input, 1 bit: sema_data_i_s holds a valid bit.
REQ-005 The block SHALL have port sema_ready_o_s, output, 1 bit: reader accepts a bit this cycle.
REQ-006 The block SHALL have port byte_data_o_s, output, 8 bits: assembled byte.
REQ-007 The block SHALL have port byte_valid_o_s, output, 1 bit: byte_data_o_s holds a valid byte.
REQ-008 The block SHALL have port byte_ready_i_s, input, 1 bit: the consumer takes the byte.
REQ-009 The block SHALL have port byte_perr_o_s, output, 1 bit: parity error flag for the presented byte, qualified by byte_valid_o_s.
REQ-010 The block SHALL have port frame_cnt_o_s, output, 8 bits: count of bytes delivered, wrapping.

Function
REQ-011 A bit SHALL transfer on a rising edge where sema_valid_i_s and sema_ready_o_s are both 1; no other edge SHALL change the shift state.
REQ-012 Bits SHALL arrive LSB first; the first accepted bit of a frame is byte bit 0.
REQ-013 The FSM SHALL have states IDLE (bit count 0), SHIFT (bit counts 1-7), PAR (bit count 8, parity build only) and STALL (frame complete, holding register occupied).
REQ-014 IDLE SHALL go to SHIFT on a bit transfer; SHIFT SHALL increment the bit count per transfer.
REQ-015 On the 8th transfer (or the parity-bit transfer, see REQ-025), the frame SHALL be complete.
REQ-016 On frame completion the byte SHALL load the holding register if it is empty or being drained that same edge; the FSM then goes to IDLE. Otherwise the FSM SHALL go to STALL.
REQ-017 sema_ready_o_s SHALL be 0 in STALL and 1 in every other state.
REQ-018 In STALL, the FSM SHALL move the assembled byte into the holding register on the edge where byte_ready_i_s is 1, then go to IDLE; sema_ready_o_s is 1 on the following cycle.
REQ-019 byte_valid_o_s SHALL rise the cycle after the final-bit transfer (1-cycle latency) when the holding register was free.
REQ-020 byte_data_o_s and byte_perr_o_s SHALL hold stable while byte_valid_o_s=1 and byte_ready_i_s=0.
REQ-021 byte_valid_o_s SHALL clear on a byte_ready_i_s handshake unless a new byte loads that same edge; in that case it stays 1 with the new data.
REQ-022 frame_cnt_o_s SHALL increment by 1 modulo 256 on each byte_valid_o_s & byte_ready_i_s handshake; the step after 255 is 0.
REQ-023 Gaps in sema_valid_i_s SHALL not affect the partial frame, however long they last.

Reset
REQ-024 While rst_s=1, the block SHALL take these values immediately: FSM IDLE, bit count 0, shift register 0x00, holding register empty, byte_valid_o_s=0, byte_data_o_s=0x00, byte_perr_o_s=0, frame_cnt_o_s=0x00, sema_ready_o_s=0. A partial frame SHALL be discarded. sema_ready_o_s SHALL go to 1 on the first rising edge after rst_s falls.

Configuration
REQ-025 With SEMA_RX_PARITY_EN defined, each frame SHALL be 9 bits: 8 data bits, then an even-parity bit (state PAR). byte_perr_o_s SHALL be 1 when the XOR of all 9 bits is 1; the byte SHALL still be delivered.
REQ-026 Without SEMA_RX_PARITY_EN, frames SHALL be 8 bits, state PAR SHALL not exist and byte_perr_o_s SHALL be tied to 0.

Verification
REQ-027 Send 8 bits 1,0,1,0,0,1,0,1 back-to-back with byte_ready_i_s=1 -> byte_valid_o_s=1 with 0xA5 one cycle after the 8th bit; frame_cnt_o_s goes to 1.
REQ-028 Hold byte_ready_i_s=0 and send 0x3C then 0xC3 -> 0x3C is held stable; sema_ready_o_s=0 after the 16th bit; raise byte_ready_i_s -> 0xC3 is presented next, then sema_ready_o_s=1.
REQ-029 Send 3 bits, assert rst_s mid-frame, then send 0x0F -> exactly one byte, 0x0F, is delivered; frame_cnt_o_s=1.
REQ-030 With SEMA_RX_PARITY_EN, send 0x81 with parity 0 -> byte_perr_o_s=0; send 0x81 with parity 1 -> byte 0x81 with byte_perr_o_s=1.
REQ-031 Deliver 257 bytes with random sema_valid_i_s gaps -> all data matches and frame_cnt_o_s wraps 255 -> 0 -> 1.
